// File: rtl/commit_unit_pkg.sv
// Shared retire-stage types: ROB head entry layout, status/op encodings and commit FSM states.
package commit_unit_pkg;

  localparam int ROB_DEPTH_DEFAULT = 32;
  localparam int ROB_IDX_W         = $clog2(ROB_DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    empty    = 2'd0,
    rob_wait = 2'd1,
    done     = 2'd2
  } rob_status_t;

  typedef enum logic [2:0] {
    op_alu   = 3'd0,
    op_load  = 3'd1,
    op_store = 3'd2,
    op_br    = 3'd3,
    op_jal   = 3'd4,
    op_jalr  = 3'd5
  } op_type_t;

  typedef struct packed {
    logic                 valid;
    rob_status_t          status;
    op_type_t             op;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 regf_we;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_data;
    logic                 br_en;
    logic                 prediction;
    logic [31:0]          pc_new;
    logic [31:0]          mem_addr;
    logic [3:0]           mem_wmask;
    logic [31:0]          mem_wdata;
  } rob_entry_t;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } commit_state_t;

  // Control-transfer ops carry a prediction that is resolved at retire.
  function automatic logic is_branch_op(input op_type_t op);
    return (op == op_br) || (op == op_jal) || (op == op_jalr);
  endfunction

endpackage

// File: rtl/commit_unit.sv
// In-order retire stage at the ROB head: regfile/RAT write, dequeue, store issue and mispredict flush.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int ORDER_W   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  rob_entry_t                   rob_head_i,
  output logic                         dequeue_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_rd_addr_o,
  output logic [31:0]                  rf_rd_data_o,
  output logic [$clog2(ROB_DEPTH)-1:0] rf_rob_idx_o,
  output logic                         flush_o,
  output logic [31:0]                  pc_redirect_o,
  output logic                         dmem_req_o,
  output logic [31:0]                  dmem_addr_o,
  output logic [3:0]                   dmem_wmask_o,
  output logic [31:0]                  dmem_wdata_o,
  input  logic                         dmem_resp_i,
  output logic                         rvfi_valid_o,
  output logic [ORDER_W-1:0]           rvfi_order_o
);

  commit_state_t        state_q, state_d;
  logic [ORDER_W-1:0]   order_q;
  rob_entry_t           store_q;
  rob_entry_t           ret_entry;
  logic                 head_ready;
  logic                 mispredict;
  logic                 store_latch;

  // The ROB shows done for a single cycle, so the retire decision must be combinational.
  assign head_ready = rob_head_i.valid && (rob_head_i.status == done);
  assign mispredict = is_branch_op(rob_head_i.op) && (rob_head_i.br_en != rob_head_i.prediction);

  // A store retires from its latched copy; everything else retires straight from the head.
  assign ret_entry  = (state_q == S_STORE_WAIT) ? store_q : rob_head_i;

  assign rvfi_order_o = order_q;

  // NOTE: every output and next-state variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    store_latch   = 1'b0;
    dequeue_o     = 1'b0;
    rf_we_o       = 1'b0;
    rf_rd_addr_o  = '0;
    rf_rd_data_o  = '0;
    rf_rob_idx_o  = '0;
    flush_o       = 1'b0;
    pc_redirect_o = '0;
    dmem_req_o    = 1'b0;
    dmem_addr_o   = '0;
    dmem_wmask_o  = '0;
    dmem_wdata_o  = '0;
    rvfi_valid_o  = 1'b0;

    // Reset must silence the strobes immediately, even with a ready head on the input.
    if (rst) begin
      case (state_q)
        S_RUN: begin
          if (head_ready) begin
            if (rob_head_i.mem_wmask != 4'h0) begin
              dmem_req_o   = 1'b1;
              dmem_addr_o  = rob_head_i.mem_addr;
              dmem_wmask_o = rob_head_i.mem_wmask;
              dmem_wdata_o = rob_head_i.mem_wdata;
              store_latch  = 1'b1;
              state_d      = S_STORE_WAIT;
            end else begin
              rvfi_valid_o = 1'b1;
              if (mispredict) begin
                // The ROB advances its own head on flush, so dequeue stays low here.
                flush_o       = 1'b1;
                pc_redirect_o = rob_head_i.pc_new;
                state_d       = S_FLUSH;
              end else begin
                dequeue_o = 1'b1;
              end
            end
          end
        end
        S_STORE_WAIT: begin
          if (dmem_resp_i) begin
            dequeue_o    = 1'b1;
            rvfi_valid_o = 1'b1;
            state_d      = S_RUN;
          end
        end
        S_FLUSH: state_d = S_RUN;
        default: state_d = S_RUN;
      endcase

      if (rvfi_valid_o) begin
        rf_we_o      = ret_entry.regf_we && (ret_entry.rd_addr != 5'd0);
        rf_rd_addr_o = ret_entry.rd_addr;
        rf_rd_data_o = ret_entry.rd_data;
        rf_rob_idx_o = ret_entry.rob_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      order_q <= '0;
      // NOTE: the latched store is a single register, so it is reset; a late response must find nothing stale.
      store_q <= '0;
    end else begin
      state_q <= state_d;
      if (rvfi_valid_o) order_q <= order_q + ORDER_W'(1);
      if (store_latch)  store_q <= rob_head_i;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: ALU/load retire, stores, mispredict flush, async reset, back-to-back.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int ORDER_W = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  rob_entry_t         rob_head_i;
  logic               dmem_resp_i;
  logic               dequeue_o, rf_we_o, flush_o, dmem_req_o, rvfi_valid_o;
  logic [4:0]         rf_rd_addr_o;
  logic [31:0]        rf_rd_data_o, pc_redirect_o, dmem_addr_o, dmem_wdata_o;
  logic [4:0]         rf_rob_idx_o;
  logic [3:0]         dmem_wmask_o;
  logic [ORDER_W-1:0] rvfi_order_o;

  commit_unit #(.ROB_DEPTH(32), .ORDER_W(ORDER_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rob_head_i   (rob_head_i),
    .dequeue_o    (dequeue_o),
    .rf_we_o      (rf_we_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_o (rf_rd_data_o),
    .rf_rob_idx_o (rf_rob_idx_o),
    .flush_o      (flush_o),
    .pc_redirect_o(pc_redirect_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wmask_o (dmem_wmask_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_resp_i  (dmem_resp_i),
    .rvfi_valid_o (rvfi_valid_o),
    .rvfi_order_o (rvfi_order_o)
  );

  always #5 clk = ~clk;

  int                 errors = 0;
  int                 checks = 0;
  logic [ORDER_W-1:0] exp_order;

  // Strobe vector {dequeue, rf_we, rvfi_valid, flush, dmem_req}.
  logic [4:0] strobes;
  assign strobes = {dequeue_o, rf_we_o, rvfi_valid_o, flush_o, dmem_req_o};

  function automatic rob_entry_t mk_idle();
    rob_entry_t e;
    e = '0;
    e.status = empty;
    e.op     = op_alu;
    return e;
  endfunction

  function automatic rob_entry_t mk_alu(input logic [4:0] rd, input logic [31:0] data,
                                        input logic [4:0] idx);
    rob_entry_t e;
    e = mk_idle();
    e.valid   = 1'b1;
    e.status  = done;
    e.regf_we = 1'b1;
    e.rd_addr = rd;
    e.rd_data = data;
    e.rob_idx = idx;
    return e;
  endfunction

  function automatic rob_entry_t mk_store(input logic [31:0] addr, input logic [3:0] wmask,
                                          input logic [31:0] wdata, input logic [4:0] idx);
    rob_entry_t e;
    e = mk_idle();
    e.valid     = 1'b1;
    e.status    = done;
    e.op        = op_store;
    e.mem_addr  = addr;
    e.mem_wmask = wmask;
    e.mem_wdata = wdata;
    e.rob_idx   = idx;
    return e;
  endfunction

  function automatic rob_entry_t mk_branch(input op_type_t op, input logic br_en, input logic pred,
                                           input logic [31:0] pc, input logic [4:0] rd,
                                           input logic we, input logic [31:0] data,
                                           input logic [4:0] idx);
    rob_entry_t e;
    e = mk_idle();
    e.valid      = 1'b1;
    e.status     = done;
    e.op         = op;
    e.br_en      = br_en;
    e.prediction = pred;
    e.pc_new     = pc;
    e.rd_addr    = rd;
    e.regf_we    = we;
    e.rd_data    = data;
    e.rob_idx    = idx;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rob_head_i  = mk_alu(5'd5, 32'h1234, 5'd3);
    dmem_resp_i = 1'b0;
    #3;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 5'b00000); end
    checks++; if (rvfi_order_o !== '0) begin errors++; $display("FAIL reset_order got=%0d exp=0", rvfi_order_o); end
    @(posedge clk); #2;
    checks++; if ({rf_rd_data_o, pc_redirect_o} !== 64'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", rf_rd_data_o, pc_redirect_o); end
    rob_head_i = mk_idle();
    rst        = 1'b1;
    exp_order  = '0;
    next_cycle();
  endtask

  task automatic test_alu();
    rob_head_i = mk_alu(5'd5, 32'h1234, 5'd3);
    #2;
    checks++; if (strobes !== 5'b11100) begin errors++; $display("FAIL alu_strobes got=%b exp=%b", strobes, 5'b11100); end
    checks++; if ({rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o} !== {5'd5, 32'h1234, 5'd3}) begin
      errors++; $display("FAIL alu_rf got=rd%0d/%h/idx%0d exp=rd5/1234/idx3", rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o);
    end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL alu_order0 got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    rob_head_i = mk_alu(5'd7, 32'hBEEF, 5'd4);
    #2;
    checks++; if (strobes !== 5'b11100) begin errors++; $display("FAIL alu2_strobes got=%b exp=%b", strobes, 5'b11100); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL alu_order1 got=%0d exp=%0d", rvfi_order_o, exp_order); end
    checks++; if (rf_rd_data_o !== 32'hBEEF) begin errors++; $display("FAIL alu2_data got=%h exp=beef", rf_rd_data_o); end
    next_cycle(); exp_order++;
    rob_head_i = mk_idle();
  endtask

  task automatic test_rd0_wait_load();
    rob_head_i = mk_alu(5'd0, 32'h55, 5'd5);
    #2;
    checks++; if (strobes !== 5'b10100) begin errors++; $display("FAIL rd0_strobes got=%b exp=%b", strobes, 5'b10100); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL rd0_order got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    rob_head_i        = mk_alu(5'd9, 32'h1, 5'd6);
    rob_head_i.status = rob_wait;
    #2;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL robwait_strobes got=%b exp=%b", strobes, 5'b00000); end
    next_cycle();
    rob_head_i    = mk_alu(5'd10, 32'hCAFE, 5'd7);
    rob_head_i.op = op_load;
    #2;
    checks++; if (strobes !== 5'b11100) begin errors++; $display("FAIL load_strobes got=%b exp=%b", strobes, 5'b11100); end
    checks++; if (rf_rd_addr_o !== 5'd10) begin errors++; $display("FAIL load_rd got=%0d exp=10", rf_rd_addr_o); end
    next_cycle(); exp_order++;
    rob_head_i = mk_idle();
  endtask

  task automatic test_store();
    rob_head_i = mk_store(32'h100, 4'hF, 32'hDEAD, 5'd8);
    #2;
    checks++; if (strobes !== 5'b00001) begin errors++; $display("FAIL st_req_strobes got=%b exp=%b", strobes, 5'b00001); end
    checks++; if ({dmem_addr_o, dmem_wmask_o, dmem_wdata_o} !== {32'h100, 4'hF, 32'hDEAD}) begin
      errors++; $display("FAIL st_bus got=%h/%h/%h exp=100/f/dead", dmem_addr_o, dmem_wmask_o, dmem_wdata_o);
    end
    next_cycle();
    // A ready head during the wait must be ignored.
    rob_head_i = mk_alu(5'd11, 32'h77, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL st_wait%0d_strobes got=%b exp=%b", i, strobes, 5'b00000); end
      next_cycle();
    end
    dmem_resp_i = 1'b1;
    #2;
    checks++; if (strobes !== 5'b10100) begin errors++; $display("FAIL st_resp_strobes got=%b exp=%b", strobes, 5'b10100); end
    checks++; if (rf_rob_idx_o !== 5'd8) begin errors++; $display("FAIL st_resp_idx got=%0d exp=8", rf_rob_idx_o); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL st_order got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    dmem_resp_i = 1'b0;
    rob_head_i  = mk_idle();
    #2;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL st_after_strobes got=%b exp=%b", strobes, 5'b00000); end
    next_cycle();
    dmem_resp_i = 1'b1;
    #2;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL run_resp_ignored got=%b exp=%b", strobes, 5'b00000); end
    next_cycle();
    dmem_resp_i = 1'b0;
  endtask

  task automatic test_branch();
    rob_head_i = mk_branch(op_br, 1'b1, 1'b0, 32'h2000, 5'd0, 1'b0, 32'h0, 5'd10);
    #2;
    checks++; if (strobes !== 5'b00110) begin errors++; $display("FAIL br_strobes got=%b exp=%b", strobes, 5'b00110); end
    checks++; if (pc_redirect_o !== 32'h2000) begin errors++; $display("FAIL br_redirect got=%h exp=2000", pc_redirect_o); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL br_order got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    rob_head_i = mk_alu(5'd12, 32'h99, 5'd11);
    #2;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL flush_hold_strobes got=%b exp=%b", strobes, 5'b00000); end
    next_cycle();
    #2;
    checks++; if (strobes !== 5'b11100) begin errors++; $display("FAIL flush_resume_strobes got=%b exp=%b", strobes, 5'b11100); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL flush_resume_order got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    rob_head_i = mk_branch(op_jal, 1'b1, 1'b0, 32'h3000, 5'd1, 1'b1, 32'h1004, 5'd12);
    #2;
    checks++; if (strobes !== 5'b01110) begin errors++; $display("FAIL jal_strobes got=%b exp=%b", strobes, 5'b01110); end
    checks++; if ({rf_rd_data_o, pc_redirect_o} !== {32'h1004, 32'h3000}) begin
      errors++; $display("FAIL jal_link got=%h/%h exp=1004/3000", rf_rd_data_o, pc_redirect_o);
    end
    next_cycle(); exp_order++;
    rob_head_i = mk_idle();
    next_cycle();
    rob_head_i = mk_branch(op_br, 1'b1, 1'b1, 32'h4000, 5'd0, 1'b0, 32'h0, 5'd13);
    #2;
    checks++; if (strobes !== 5'b10100) begin errors++; $display("FAIL br_ok_strobes got=%b exp=%b", strobes, 5'b10100); end
    checks++; if (pc_redirect_o !== 32'h0) begin errors++; $display("FAIL br_ok_redirect got=%h exp=0", pc_redirect_o); end
    next_cycle(); exp_order++;
    rob_head_i = mk_idle();
  endtask

  task automatic test_reset_mid_store();
    rob_head_i = mk_store(32'h200, 4'h3, 32'h5A5A, 5'd14);
    #2;
    checks++; if (strobes !== 5'b00001) begin errors++; $display("FAIL rst_st_req got=%b exp=%b", strobes, 5'b00001); end
    next_cycle();
    rob_head_i = mk_alu(5'd13, 32'h42, 5'd15);
    #2;
    rst = 1'b0;
    exp_order = '0;
    #1;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL rst_async_strobes got=%b exp=%b", strobes, 5'b00000); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL rst_async_order got=%0d exp=0", rvfi_order_o); end
    rob_head_i = mk_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    dmem_resp_i = 1'b1;
    #2;
    checks++; if (strobes !== 5'b00000) begin errors++; $display("FAIL rst_late_resp got=%b exp=%b", strobes, 5'b00000); end
    next_cycle();
    rob_head_i = mk_alu(5'd13, 32'h42, 5'd15);
    #2;
    checks++; if (strobes !== 5'b11100) begin errors++; $display("FAIL rst_resume_strobes got=%b exp=%b", strobes, 5'b11100); end
    checks++; if (rvfi_order_o !== exp_order) begin errors++; $display("FAIL rst_resume_order got=%0d exp=%0d", rvfi_order_o, exp_order); end
    next_cycle(); exp_order++;
    dmem_resp_i = 1'b0;
    rob_head_i  = mk_idle();
  endtask

  task automatic test_back_to_back();
    int deq_count;
    int bad;
    deq_count = 0;
    bad       = 0;
    for (int i = 0; i < 40; i++) begin
      rob_head_i = mk_alu(5'((i % 31) + 1), 32'(i * 3), 5'(i % 32));
      #2;
      if (dequeue_o === 1'b1) deq_count++;
      checks++; if (strobes !== 5'b11100 || rvfi_order_o !== exp_order) begin
        errors++; bad++;
        if (bad <= 4) $display("FAIL b2b[%0d] strobes=%b order=%0d exp=%b/%0d", i, strobes, rvfi_order_o, 5'b11100, exp_order);
      end
      next_cycle(); exp_order++;
    end
    rob_head_i = mk_idle();
    checks++; if (deq_count !== 40) begin errors++; $display("FAIL b2b_count got=%0d exp=40", deq_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    exp_order = '0;
    test_reset();
    test_alu();
    test_rd0_wait_load();
    test_store();
    test_branch();
    test_reset_mid_store();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
